ikun_frame_pair_sync: RTL and testbench
=======================================

// Module: ikun_frame_pair_sync
// PURPOSE
//  Sequencer in front of the frame-difference core. It aligns the live camera stream (s0) with the previous-frame stream read back by VDMA (s1).
//  It discards beats until both streams sit on start-of-frame, then releases them in lock-step as one paired stream.
//  It checks geometry and restarts alignment on any sync loss, and it counts completed paired frames.
// PARAMETERS
//  IMG_HDISP  1280  active pixels per line
//  IMG_VDISP  720   active lines per frame
//  DATA_W     24    pixel width of each stream
// PORTS
//  clk        in   1       single clock for all logic
//  rst_n      in   1       asynchronous active-low reset
//  enable     in   1       1 = sequence frames; 0 = stop at the next frame boundary
//  s0_tdata   in   DATA_W  camera pixel
//  s0_tvalid  in   1
//  s0_tready  out  1
//  s0_tuser   in   1       start of frame (SOF)
//  s0_tlast   in   1       end of line (EOL)
//  s1_tdata   in   DATA_W  VDMA previous-frame pixel
//  s1_tvalid  in   1
//  s1_tready  out  1
//  s1_tuser   in   1       SOF
//  s1_tlast   in   1       EOL
//  p_cur      out  DATA_W  paired current pixel (from s0)
//  p_prev     out  DATA_W  paired previous pixel (from s1)
//  p_tvalid   out  1
//  p_tready   in   1
//  p_tuser    out  1       high on pixel (0,0)
//  p_tlast    out  1       high on x == IMG_HDISP-1
//  frame_cnt  out  16      completed paired frames; wraps 0xFFFF -> 0
//  sync_err   out  1       one-cycle pulse on each detected misalignment
//  state_o    out  2       0 = IDLE, 1 = SEEK, 2 = RUN
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs 0; FSM in IDLE; x/y counters 0; output register empty.
//  IDLE: s0_tready = s1_tready = 0. Go to SEEK when enable = 1.
//  SEEK: per stream, tready = 1 while that stream presents tvalid & !tuser, so non-SOF beats are dropped.
//   - A stream presenting tvalid & tuser is held (its tready = 0) until the other stream also presents SOF.
//   - Both streams holding SOF: next cycle go to RUN. The SOF beats are not consumed in SEEK.
//   - enable = 0 in SEEK: go to IDLE immediately.
//  RUN (joint handshake): load = s0_tvalid & s1_tvalid & (!p_tvalid | p_tready).
//   - s0_tready = s1_tready = load. A beat is never consumed from one stream alone.
//   - Output register: on load, p_cur/p_prev take the s0/s1 data, p_tvalid = 1, p_tuser = (x==0 & y==0), p_tlast = (x==IMG_HDISP-1).
//   - On p_tvalid & p_tready & !load, p_tvalid goes to 0. Latency: 1 cycle from the joint input handshake to p_tvalid.
//   - Counters: x increments on each load and wraps to 0 at IMG_HDISP-1, which also increments y.
//     y wraps to 0 at IMG_VDISP-1; that load increments frame_cnt.
//  Sync checks, evaluated at the moment of load:
//   - Either tuser must equal (x==0 & y==0).
//   - Either tlast must equal (x==IMG_HDISP-1).
//  Any check mismatch:
//   - the offending beat pair is consumed but not loaded;
//   - sync_err pulses for 1 cycle;
//   - x and y clear to 0; FSM goes to SEEK.
//   - A beat already in the output register still drains normally.
//  Frame end (last load of the frame): if enable = 1, stay in RUN and expect SOF next; if enable = 0, go to IDLE.
//   enable falling mid-frame has no effect until frame end.
//  Simultaneous frame end and mismatch on the same beat: the mismatch wins; frame_cnt does not increment.
//  p_tready low never drops data: load stalls, and both input treadys stay 0 while the register is full.
//  Reset asserted mid-frame: immediate return to the reset state. After release, realignment starts in SEEK via IDLE.
//  No combinational path from p_tready to p_tvalid. s*_tready may depend combinationally on s*_tvalid and p_tready.
// TESTING (bench uses IMG_HDISP=8, IMG_VDISP=4)
//  1. Both streams start on SOF, p_tready = 1, enable = 1 -> 32 paired beats, p_tuser on beat 0, p_tlast on beats 7/15/23/31, frame_cnt = 1, no sync_err.
//  2. s1 starts 3 beats into its frame, s0 on SOF -> s0 held on SOF, 5 s1 beats dropped; pairing starts at the next s1 SOF; first p_cur/p_prev are both pixel (0,0).
//  3. s0 tlast asserted at x=5 in line 1 -> sync_err pulses once, state_o goes to 1; next aligned frame pairs correctly; frame_cnt unchanged for the broken frame.
//  4. p_tready toggling 1/0 every cycle, s1_tvalid random 50% -> all 32 pairs delivered in order, none duplicated or lost, and s0/s1 each consume exactly 32 beats.
//  5. enable dropped at pixel 10 of frame 2 -> frame 2 completes (frame_cnt = 2), state_o = 0, and both tready stay 0 afterwards.
//  6. rst_n pulsed low at pixel 20 -> all outputs 0 during reset; after release and enable = 1, the block resyncs on the next common SOF with frame_cnt restarting from 0.

Source files
------------

// File: rtl/ikun_frame_pair_sync.sv
// Pairs live camera (s0) and previous-frame (s1) streams into one lock-step stream.
// Latency: 1 cycle from joint input handshake to p_tvalid.
// Backpressure: p_tready low stalls the output register; both inputs are then held (tready = 0).
module ikun_frame_pair_sync #(
  parameter int IMG_HDISP = 1280,
  parameter int IMG_VDISP = 720,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] s0_tdata,
  input  logic              s0_tvalid,
  output logic              s0_tready,
  input  logic              s0_tuser,
  input  logic              s0_tlast,
  input  logic [DATA_W-1:0] s1_tdata,
  input  logic              s1_tvalid,
  output logic              s1_tready,
  input  logic              s1_tuser,
  input  logic              s1_tlast,
  output logic [DATA_W-1:0] p_cur,
  output logic [DATA_W-1:0] p_prev,
  output logic              p_tvalid,
  input  logic              p_tready,
  output logic              p_tuser,
  output logic              p_tlast,
  output logic [15:0]       frame_cnt,
  output logic              sync_err,
  output logic [1:0]        state_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEEK = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam int XW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int YW = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_VDISP - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [15:0]       r_frame_cnt;
  logic              r_sync_err;
  logic [DATA_W-1:0] r_p_cur;
  logic [DATA_W-1:0] r_p_prev;
  logic              r_p_vld;
  logic              r_p_user;
  logic              r_p_last;

  logic w_first;
  logic w_eol;
  logic w_eof;
  logic w_room;
  logic w_hs;
  logic w_mis;
  logic w_load;
  logic w_bad;
  logic w_both_sof;

  assign w_first    = (r_x == '0) && (r_y == '0);
  assign w_eol      = (r_x == X_LAST);
  assign w_eof      = w_eol && (r_y == Y_LAST);
  // Output register can take a beat when empty or being drained this cycle.
  assign w_room     = !r_p_vld || p_tready;
  // Joint handshake: a beat pair is consumed only when both streams offer one.
  assign w_hs       = (r_state == ST_RUN) && s0_tvalid && s1_tvalid && w_room;
  assign w_mis      = (s0_tuser != w_first) || (s1_tuser != w_first) ||
                      (s0_tlast != w_eol)   || (s1_tlast != w_eol);
  assign w_load     = w_hs && !w_mis;
  assign w_bad      = w_hs && w_mis;
  assign w_both_sof = s0_tvalid && s0_tuser && s1_tvalid && s1_tuser;

  // Input ready: drop non-SOF beats while seeking, joint handshake while running.
  always_comb begin
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (r_state)
      ST_SEEK: begin
        s0_tready = s0_tvalid && !s0_tuser;
        s1_tready = s1_tvalid && !s1_tuser;
      end
      ST_RUN: begin
        s0_tready = w_hs;
        s1_tready = w_hs;
      end
      default: ;
    endcase
  end

  // Next-state: mismatch beats frame end; enable is only honoured at frame end in RUN.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (enable) w_state_nxt = ST_SEEK;
      ST_SEEK: begin
        if (!enable)         w_state_nxt = ST_IDLE;
        else if (w_both_sof) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_bad)                            w_state_nxt = ST_SEEK;
        else if (w_load && w_eof && !enable)  w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pixel position and completed-frame counting; a misaligned pair restarts geometry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_frame_cnt <= '0;
    end else if (w_bad) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_load) begin
      if (w_eol) begin
        r_x <= '0;
        if (r_y == Y_LAST) begin
          r_y         <= '0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end else begin
          r_y <= r_y + 1'b1;
        end
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Paired output register; a resident beat drains even across a mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_vld  <= 1'b0;
      r_p_cur  <= '0;
      r_p_prev <= '0;
      r_p_user <= 1'b0;
      r_p_last <= 1'b0;
    end else if (w_load) begin
      r_p_vld  <= 1'b1;
      r_p_cur  <= s0_tdata;
      r_p_prev <= s1_tdata;
      r_p_user <= w_first;
      r_p_last <= w_eol;
    end else if (p_tready) begin
      r_p_vld <= 1'b0;
    end
  end

  // One-cycle misalignment pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync_err <= 1'b0;
    else        r_sync_err <= w_bad;
  end

  assign p_cur     = r_p_cur;
  assign p_prev    = r_p_prev;
  assign p_tvalid  = r_p_vld;
  assign p_tuser   = r_p_user;
  assign p_tlast   = r_p_last;
  assign frame_cnt = r_frame_cnt;
  assign sync_err  = r_sync_err;
  assign state_o   = r_state;

endmodule

// File: tb/tb_ikun_frame_pair_sync.sv
// Self-checking bench for ikun_frame_pair_sync on an 8x4 image.
// Sources are fed from per-stream beat queues; expected pairs go to a scoreboard queue.
// Output pairs are popped and compared as they leave the DUT.
module tb_ikun_frame_pair_sync;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int DW = 24;
  localparam int NP = H * V;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] s0_tdata, s1_tdata;
  logic          s0_tvalid, s0_tready, s0_tuser, s0_tlast;
  logic          s1_tvalid, s1_tready, s1_tuser, s1_tlast;
  logic [DW-1:0] p_cur, p_prev;
  logic          p_tvalid, p_tready, p_tuser, p_tlast;
  logic [15:0]   frame_cnt;
  logic          sync_err;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  ikun_frame_pair_sync #(.IMG_HDISP(H), .IMG_VDISP(V), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .p_cur(p_cur), .p_prev(p_prev), .p_tvalid(p_tvalid), .p_tready(p_tready),
    .p_tuser(p_tuser), .p_tlast(p_tlast),
    .frame_cnt(frame_cnt), .sync_err(sync_err), .state_o(state_o)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } beat_t;

  beat_t           q0[$];
  beat_t           q1[$];
  logic [2*DW+1:0] expq[$];

  int         n_vec = 0;
  int         n_fail = 0;
  int         c0, c1, n_err;
  logic [1:0] err_state;
  bit         rnd1, tog, any_rdy, hs0, hs1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int s, input int f, input int idx);
    return {1'(s), 7'(f), 8'(idx / H), 8'(idx % H)};
  endfunction

  // Push beats idx from..to of frame f on stream s; bad flips tlast on that index.
  task automatic add_src(input int s, input int f, input int from, input int to, input int bad);
    beat_t b;
    for (int i = from; i <= to; i++) begin
      b.d = pix(s, f, i);
      b.u = (i == 0);
      b.l = ((i % H) == H - 1) ^ (i == bad);
      if (s == 0) q0.push_back(b);
      else        q1.push_back(b);
    end
  endtask

  task automatic add_exp(input int f0, input int f1, input int from, input int to);
    for (int i = from; i <= to; i++)
      expq.push_back({pix(0, f0, i), pix(1, f1, i), 1'(i == 0), 1'((i % H) == H - 1)});
  endtask

  task automatic drive_src();
    bit gate;
    s0_tvalid = (q0.size() != 0);
    if (s0_tvalid) {s0_tdata, s0_tuser, s0_tlast} = q0[0];
    else           {s0_tdata, s0_tuser, s0_tlast} = '0;
    gate = rnd1 ? ($urandom_range(0, 1) == 1) : 1'b1;
    s1_tvalid = (q1.size() != 0) && gate;
    if (s1_tvalid) {s1_tdata, s1_tuser, s1_tlast} = q1[0];
    else           {s1_tdata, s1_tuser, s1_tlast} = '0;
  endtask

  // One clock: sample/score at negedge, advance sources just after posedge.
  task automatic step();
    logic [2*DW+1:0] e;
    @(negedge clk);
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (rst_n) begin
      hs0 = s0_tvalid && s0_tready;
      hs1 = s1_tvalid && s1_tready;
      if (p_tvalid && p_tready) begin
        if (expq.size() == 0) chk("extra_out", 64'(1), 64'(0));
        else begin
          e = expq.pop_front();
          chk("pair", 64'({p_cur, p_prev, p_tuser, p_tlast}), 64'(e));
        end
      end
      if (sync_err) begin
        n_err++;
        err_state = state_o;
      end
      if (s0_tready || s1_tready) any_rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    if (hs0) begin void'(q0.pop_front()); c0++; end
    if (hs1) begin void'(q1.pop_front()); c1++; end
    if (tog) p_tready = !p_tready;
    drive_src();
  endtask

  task automatic wait_exp(input int budget, input string tag);
    int n = 0;
    while ((expq.size() != 0 || p_tvalid) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(expq.size()), 64'(0));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pvld"},  64'(p_tvalid),  64'(0));
    chk({tag, "_pcur"},  64'(p_cur),     64'(0));
    chk({tag, "_pprev"}, 64'(p_prev),    64'(0));
    chk({tag, "_puser"}, 64'(p_tuser),   64'(0));
    chk({tag, "_plast"}, 64'(p_tlast),   64'(0));
    chk({tag, "_fcnt"},  64'(frame_cnt), 64'(0));
    chk({tag, "_serr"},  64'(sync_err),  64'(0));
    chk({tag, "_state"}, 64'(state_o),   64'(0));
    chk({tag, "_rdy0"},  64'(s0_tready), 64'(0));
    chk({tag, "_rdy1"},  64'(s1_tready), 64'(0));
  endtask

  task automatic do_reset(input string tag);
    rst_n  = 1'b0;
    enable = 1'b0;
    q0.delete();
    q1.delete();
    expq.delete();
    drive_src();
    repeat (3) step();
    reset_checks(tag);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable = 1'b0; p_tready = 1'b1;
    rnd1 = 1'b0; tog = 1'b0; any_rdy = 1'b0;
    c0 = 0; c1 = 0; n_err = 0; err_state = 2'd3;
    drive_src();

    // 1: aligned streams, one full frame
    do_reset("rst1");
    enable = 1'b1;
    add_src(0, 1, 0, NP - 1, -1);
    add_src(1, 1, 0, NP - 1, -1);
    add_exp(1, 1, 0, NP - 1);
    drive_src();
    wait_exp(500, "t1_done");
    chk("t1_fcnt", 64'(frame_cnt), 64'(1));
    chk("t1_nerr", 64'(n_err), 64'(0));
    chk("t1_state", 64'(state_o), 64'(2));

    // 2: s1 joins mid-frame; s0 held on SOF until s1's next SOF
    do_reset("rst2");
    enable = 1'b1;
    c0 = 0; c1 = 0; n_err = 0;
    add_src(0, 2, 0, NP - 1, -1);
    add_src(1, 2, 3, H - 1, -1);
    add_src(1, 3, 0, NP - 1, -1);
    add_exp(2, 3, 0, NP - 1);
    drive_src();
    wait_exp(500, "t2_done");
    chk("t2_c0", 64'(c0), 64'(NP));
    chk("t2_c1", 64'(c1), 64'(NP + 5));
    chk("t2_fcnt", 64'(frame_cnt), 64'(1));
    chk("t2_nerr", 64'(n_err), 64'(0));

    // 3: bad EOL on s0 at x=5 of line 1, then a clean frame
    c0 = 0; c1 = 0; n_err = 0; err_state = 2'd3;
    add_src(0, 4, 0, NP - 1, H + 5);
    add_src(1, 4, 0, NP - 1, -1);
    add_src(0, 5, 0, NP - 1, -1);
    add_src(1, 5, 0, NP - 1, -1);
    add_exp(4, 4, 0, H + 4);
    add_exp(5, 5, 0, NP - 1);
    drive_src();
    wait_exp(800, "t3_done");
    chk("t3_nerr", 64'(n_err), 64'(1));
    chk("t3_errstate", 64'(err_state), 64'(1));
    chk("t3_fcnt", 64'(frame_cnt), 64'(2));

    // 4: output backpressure toggling, s1 valid random
    c0 = 0; c1 = 0; n_err = 0;
    rnd1 = 1'b1; tog = 1'b1;
    add_src(0, 6, 0, NP - 1, -1);
    add_src(1, 6, 0, NP - 1, -1);
    add_exp(6, 6, 0, NP - 1);
    drive_src();
    wait_exp(2000, "t4_done");
    rnd1 = 1'b0; tog = 1'b0; p_tready = 1'b1;
    drive_src();
    chk("t4_c0", 64'(c0), 64'(NP));
    chk("t4_c1", 64'(c1), 64'(NP));
    chk("t4_fcnt", 64'(frame_cnt), 64'(3));

    // 5: enable dropped at pixel 10 of frame 2; frame 2 must finish
    do_reset("rst5");
    enable = 1'b1;
    c0 = 0; c1 = 0;
    add_src(0, 7, 0, NP - 1, -1);
    add_src(1, 7, 0, NP - 1, -1);
    add_src(0, 8, 0, NP - 1, -1);
    add_src(1, 8, 0, NP - 1, -1);
    add_src(0, 9, 0, NP - 1, -1);
    add_src(1, 9, 0, NP - 1, -1);
    add_exp(7, 7, 0, NP - 1);
    add_exp(8, 8, 0, NP - 1);
    drive_src();
    n = 0;
    while (c0 < NP + 10 && n < 500) begin step(); n++; end
    chk("t5_reach", 64'(c0 >= NP + 10), 64'(1));
    enable = 1'b0;
    wait_exp(500, "t5_done");
    any_rdy = 1'b0;
    repeat (20) step();
    chk("t5_fcnt", 64'(frame_cnt), 64'(2));
    chk("t5_state", 64'(state_o), 64'(0));
    chk("t5_anyrdy", 64'(any_rdy), 64'(0));
    chk("t5_q0", 64'(q0.size()), 64'(NP));
    chk("t5_q1", 64'(q1.size()), 64'(NP));

    // 6: reset mid-frame, then resync on the next common SOF
    enable = 1'b1;
    add_exp(9, 9, 0, NP - 1);
    c0 = 0;
    n = 0;
    while (c0 < 20 && n < 500) begin step(); n++; end
    chk("t6_reach", 64'(c0 >= 20), 64'(1));
    rst_n = 1'b0;
    step();
    step();
    reset_checks("rst6");
    expq.delete();
    n_err = 0;
    add_src(0, 10, 0, NP - 1, -1);
    add_src(1, 10, 0, NP - 1, -1);
    add_exp(10, 10, 0, NP - 1);
    rst_n = 1'b1;
    drive_src();
    wait_exp(800, "t6_done");
    chk("t6_fcnt", 64'(frame_cnt), 64'(1));
    chk("t6_nerr", 64'(n_err), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
